// File: rtl/seg_scan_display.sv
// seg_scan_display: binary-to-BCD conversion of a 16-bit value and a
// multiplexed eight-digit active-low seven-segment scanner.
// Digits 0-4 show the stored value with leading-zero blanking, digit 5 is
// always blank, digit 6 shows the source module code, digit 7 shows prog.
module seg_scan_display #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_valid,
  input  logic [15:0] data,
  input  logic [2:0]  prog,
  input  logic [1:0]  modules,
  output logic [7:0]  an,
  output logic [7:0]  dec_ddp
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state;
  logic [15:0]   bin;
  logic [19:0]   bcd;
  logic [3:0]    step;
  logic [15:0]   pend_data;
  logic          pend_valid;
  logic [19:0]   disp_bcd;
  logic [19:0]   bcd_adj;

  logic [PW-1:0] prescaler;
  logic [2:0]    scan_idx;

  logic [4:0]    show;
  logic [3:0]    nib;
  logic          lit;
  logic [7:0]    seg_next;
  logic [7:0]    an_next;

  // Seven-segment pattern for a decimal digit; anything else is blank.
  function automatic logic [7:0] enc_digit(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'h03;
      4'd1:    s = 8'h9F;
      4'd2:    s = 8'h25;
      4'd3:    s = 8'h0D;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h49;
      4'd6:    s = 8'h41;
      4'd7:    s = 8'h1F;
      4'd8:    s = 8'h01;
      4'd9:    s = 8'h09;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  // Add-3 correction on every BCD nibble that is 5 or more, ahead of the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 5; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Double-dabble FSM; the display register only changes from DONE so a
  // partially converted value is never shown.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bin        <= '0;
      bcd        <= '0;
      step       <= '0;
      pend_data  <= '0;
      pend_valid <= 1'b0;
      disp_bcd   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (data_valid) begin
            bin   <= data;
            bcd   <= '0;
            step  <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          bcd  <= {bcd_adj[18:0], bin[15]};
          bin  <= {bin[14:0], 1'b0};
          step <= step + 4'd1;
          if (step == 4'd15) state <= DONE;
          if (data_valid) begin
            pend_data  <= data;
            pend_valid <= 1'b1;
          end
        end
        DONE: begin
          disp_bcd <= bcd;
          if (data_valid) begin
            bin        <= data;
            bcd        <= '0;
            step       <= '0;
            pend_valid <= 1'b0;
            state      <= SHIFT;
          end else if (pend_valid) begin
            bin        <= pend_data;
            bcd        <= '0;
            step       <= '0;
            pend_valid <= 1'b0;
            state      <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Prescaler sets the dwell time of each digit; scan index wraps 7 -> 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler <= '0;
      scan_idx  <= '0;
    end else if (prescaler == PRE_LAST) begin
      prescaler <= '0;
      scan_idx  <= scan_idx + 3'd1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // Select anode and segment pattern for the digit currently being scanned.
  always_comb begin
    show    = '0;
    show[0] = 1'b1;
    for (int i = 1; i < 5; i++) show[i] = (disp_bcd >> (4*i)) != 20'd0;
    nib      = 4'd0;
    lit      = 1'b0;
    seg_next = 8'hFF;
    case (scan_idx)
      3'd0: begin nib = disp_bcd[3:0];   lit = (modules != 2'd0) && show[0]; end
      3'd1: begin nib = disp_bcd[7:4];   lit = (modules != 2'd0) && show[1]; end
      3'd2: begin nib = disp_bcd[11:8];  lit = (modules != 2'd0) && show[2]; end
      3'd3: begin nib = disp_bcd[15:12]; lit = (modules != 2'd0) && show[3]; end
      3'd4: begin nib = disp_bcd[19:16]; lit = (modules != 2'd0) && show[4]; end
      3'd6: lit = (modules != 2'd0);
      3'd7: lit = 1'b1;
      default: lit = 1'b0;
    endcase
    if (lit) begin
      if (scan_idx == 3'd6) begin
        case (modules)
          2'd1:    seg_next = 8'h71;
          2'd2:    seg_next = 8'hE1;
          default: seg_next = 8'hFD;
        endcase
      end else if (scan_idx == 3'd7) begin
        seg_next = enc_digit({1'b0, prog});
      end else begin
        seg_next = enc_digit(nib);
      end
    end
    an_next = lit ? ~(8'd1 << scan_idx) : 8'hFF;
  end

  // Register the display outputs so they are glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      an      <= 8'hFF;
      dec_ddp <= 8'hFF;
    end else begin
      an      <= an_next;
      dec_ddp <= seg_next;
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display: directed stimulus with a cycle-level decimal model of
// the display and hand-written per-digit expectations for each pattern.
module tb_seg_scan_display;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_valid;
  logic [15:0] data;
  logic [2:0]  prog;
  logic [1:0]  modules;
  logic [7:0]  an;
  logic [7:0]  dec_ddp;

  int compared   = 0;
  int mismatched = 0;

  // model state
  int         m_cyc;
  int         m_disp;
  bit         m_busy;
  int         m_done_at;
  int         m_conv;
  bit         m_pend_v;
  int         m_pend;
  logic [7:0] exp_an;
  logic [7:0] exp_seg;
  bit         exp_valid = 1'b0;
  int         exp_slot  = -1;
  int         pow10[5]  = '{1, 10, 100, 1000, 10000};

  logic [7:0] frame_an[8];
  logic [7:0] frame_seg[8];

  seg_scan_display #(.REFRESH_DIV(DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_valid (data_valid),
    .data       (data),
    .prog       (prog),
    .modules    (modules),
    .an         (an),
    .dec_ddp    (dec_ddp)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  function automatic logic [7:0] seg_of(input int d);
    case (d)
      0: return 8'h03;
      1: return 8'h9F;
      2: return 8'h25;
      3: return 8'h0D;
      4: return 8'h99;
      5: return 8'h49;
      6: return 8'h41;
      7: return 8'h1F;
      8: return 8'h01;
      9: return 8'h09;
      default: return 8'hFF;
    endcase
  endfunction

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // What the display must show in a slot, from the decimal value.
  task automatic expected(input int slot, input int value, input logic [1:0] mods,
                          input logic [2:0] pg, output logic [7:0] ea, output logic [7:0] es);
    ea = 8'hFF;
    es = 8'hFF;
    if (slot < 5) begin
      if (mods != 2'd0 && (slot == 0 || value >= pow10[slot])) begin
        ea = ~(8'd1 << slot);
        es = seg_of((value / pow10[slot]) % 10);
      end
    end else if (slot == 6) begin
      if (mods != 2'd0) begin
        ea = 8'hBF;
        es = (mods == 2'd1) ? 8'h71 : (mods == 2'd2) ? 8'hE1 : 8'hFD;
      end
    end else if (slot == 7) begin
      ea = 8'h7F;
      es = seg_of(int'(pg));
    end
  endtask

  task automatic start_conv(input int v);
    m_conv    = v;
    m_done_at = m_cyc + 17;
    m_busy    = 1'b1;
  endtask

  // Reference model: advances one clock edge at a time.
  always @(posedge clk) begin
    if (rst === 1'b1) begin
      exp_an    = 8'hFF;
      exp_seg   = 8'hFF;
      exp_valid = 1'b1;
      exp_slot  = -1;
      m_cyc     = 0;
      m_disp    = 0;
      m_busy    = 1'b0;
      m_pend_v  = 1'b0;
    end else if (exp_valid) begin
      m_cyc++;
      exp_slot = ((m_cyc - 1) / DIV) % 8;
      expected(exp_slot, m_disp, modules, prog, exp_an, exp_seg);
      if (m_busy && m_cyc == m_done_at) begin
        m_disp = m_conv;
        if (data_valid) begin
          start_conv(int'(data));
          m_pend_v = 1'b0;
        end else if (m_pend_v) begin
          start_conv(m_pend);
          m_pend_v = 1'b0;
        end else begin
          m_busy = 1'b0;
        end
      end else if (data_valid) begin
        if (m_busy) begin
          m_pend   = int'(data);
          m_pend_v = 1'b1;
        end else begin
          start_conv(int'(data));
        end
      end
    end
  end

  // Compare DUT outputs to the model every cycle and keep a per-slot snapshot.
  always @(negedge clk) begin
    if (exp_valid) begin
      check_output("cycle_an", an, exp_an);
      check_output("cycle_seg", dec_ddp, exp_seg);
      if (exp_slot >= 0) begin
        frame_an[exp_slot]  = an;
        frame_seg[exp_slot] = dec_ddp;
      end
    end
  end

  task automatic apply_stimulus(input logic [15:0] v);
    @(negedge clk);
    data       = v;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic wait_frame();
    repeat (8 * DIV + 3) @(negedge clk);
  endtask

  task automatic check_blank(input string name, input int first, input int last);
    for (int i = first; i <= last; i++) check_output(name, frame_an[i], 8'hFF);
  endtask

  // Directed sequence.
  initial begin
    rst        = 1'b1;
    data_valid = 1'b0;
    data       = '0;
    prog       = 3'd3;
    modules    = 2'd1;
    repeat (3) @(negedge clk);
    check_output("reset_an", an, 8'hFF);
    check_output("reset_seg", dec_ddp, 8'hFF);
    rst = 1'b0;

    // idle display after reset
    wait_frame();
    check_output("idle_d0_seg", frame_seg[0], 8'h03);
    check_output("idle_d0_an", frame_an[0], 8'hFE);
    check_output("idle_d6_seg", frame_seg[6], 8'h71);
    check_output("idle_d6_an", frame_an[6], 8'hBF);
    check_output("idle_d7_seg", frame_seg[7], 8'h0D);
    check_output("idle_d7_an", frame_an[7], 8'h7F);
    check_blank("idle_blank", 1, 5);

    // 12345
    apply_stimulus(16'd12345);
    repeat (20) @(negedge clk);
    wait_frame();
    check_output("v12345_d0", frame_seg[0], 8'h49);
    check_output("v12345_d1", frame_seg[1], 8'h99);
    check_output("v12345_d2", frame_seg[2], 8'h0D);
    check_output("v12345_d3", frame_seg[3], 8'h25);
    check_output("v12345_d4", frame_seg[4], 8'h9F);

    // full-scale value
    apply_stimulus(16'd65535);
    repeat (20) @(negedge clk);
    wait_frame();
    check_output("v65535_d0", frame_seg[0], 8'h49);
    check_output("v65535_d1", frame_seg[1], 8'h0D);
    check_output("v65535_d2", frame_seg[2], 8'h49);
    check_output("v65535_d3", frame_seg[3], 8'h49);
    check_output("v65535_d4", frame_seg[4], 8'h41);

    // second strobe five cycles into a conversion is queued
    apply_stimulus(16'd65535);
    repeat (3) @(negedge clk);
    apply_stimulus(16'd7);
    repeat (40) @(negedge clk);
    wait_frame();
    check_output("queued7_d0", frame_seg[0], 8'h1F);
    check_blank("queued7_blank", 1, 5);

    // last pending write wins
    apply_stimulus(16'd99);
    apply_stimulus(16'd10);
    apply_stimulus(16'd20);
    apply_stimulus(16'd30);
    repeat (40) @(negedge clk);
    wait_frame();
    check_output("lastwins_d0", frame_seg[0], 8'h03);
    check_output("lastwins_d1", frame_seg[1], 8'h0D);
    check_blank("lastwins_blank", 2, 5);

    // reset during SHIFT
    apply_stimulus(16'd500);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_output("midrst_an", an, 8'hFF);
    check_output("midrst_seg", dec_ddp, 8'hFF);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    wait_frame();
    check_output("postrst_d0", frame_seg[0], 8'h03);
    check_blank("postrst_blank", 1, 5);

    // module select blanking keeps the stored value
    apply_stimulus(16'd42);
    repeat (20) @(negedge clk);
    modules = 2'd0;
    prog    = 3'd7;
    wait_frame();
    check_blank("mod0_blank", 0, 6);
    check_output("mod0_d7", frame_seg[7], 8'h1F);
    modules = 2'd2;
    wait_frame();
    check_output("mod2_d0", frame_seg[0], 8'h25);
    check_output("mod2_d1", frame_seg[1], 8'h99);
    check_output("mod2_d6", frame_seg[6], 8'hE1);
    check_blank("mod2_blank", 2, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
